// File: rtl/bp_pkg.sv
// Shared definitions for the branch target predictor: counter encodings,
// default entry layout and PC index/tag extraction helpers.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] CTR_RESET = WNT;
  localparam logic [1:0] CTR_ALLOC = WT;

  localparam int BP_XLEN  = 32;
  localparam int BP_TAG_W = 8;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic [1:0]          ctr;
  } bp_entry_t;

  // PCs are widened to 64 bits so one helper serves any XLEN up to 64
  function automatic logic [31:0] bp_index(input logic [63:0] pc, input int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  function automatic logic [31:0] bp_tag(input logic [63:0] pc, input int idx_w,
                                         input int tag_w);
    logic [63:0] mask;
    mask = (64'd1 << tag_w) - 64'd1;
    return 32'((pc >> (idx_w + 2)) & mask);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a 2-bit saturating direction counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc && !dec && ctr != ST)
      ctr_next = ctr + 2'd1;
    else if (dec && !inc && ctr != SNT)
      ctr_next = ctr - 2'd1;
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; zero-latency lookup for IF,
// learning from EX/MEM. Define BP_PERF_CNT_EN to add lookup/update/mispredict counters.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
`ifdef BP_PERF_CNT_EN
  output logic [31:0]     perf_lookups,
  output logic [31:0]     perf_updates,
  output logic [31:0]     perf_mispred,
`endif
  input  logic            bp_flush
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic            valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             upd_hit;
  logic [1:0]       ctr_next;

  assign l_idx = IDX_W'(bp_index(64'(if_pc), IDX_W));
  assign l_tag = TAG_W'(bp_tag(64'(if_pc), IDX_W, TAG_W));
  assign u_idx = IDX_W'(bp_index(64'(upd_pc), IDX_W));
  assign u_tag = TAG_W'(bp_tag(64'(upd_pc), IDX_W, TAG_W));

  // Lookup reads the flops directly, so same-cycle updates are not visible yet
  always_comb begin
    pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = pred_hit && ctr_q[l_idx][1];
    pred_target = pred_taken ? target_q[l_idx] : if_pc + XLEN'(4);
  end

  assign upd_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  bp_sat_counter u_sat_counter (
    .ctr      (ctr_q[u_idx]),
    .inc      (upd_taken),
    .dec      (!upd_taken),
    .ctr_next (ctr_next)
  );

  // Flush only clears valid bits and takes priority over a concurrent update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (bp_flush) begin
      for (int i = 0; i < ENTRIES; i++)
        valid_q[i] <= 1'b0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[u_idx] <= ctr_next;
        if (upd_taken)
          target_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= CTR_ALLOC;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [XLEN-1:0] prev_pc_q;
  logic            u_pred_taken;
  logic [XLEN-1:0] u_pred_target;
  logic            mispred;

  // Prediction the IF stage would have made for upd_pc with the current table
  always_comb begin
    u_pred_taken  = upd_hit && ctr_q[u_idx][1];
    u_pred_target = u_pred_taken ? target_q[u_idx] : upd_pc + XLEN'(4);
    mispred       = (u_pred_taken != upd_taken) ||
                    (upd_taken && (u_pred_target != upd_target));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pc_q    <= '0;
      perf_lookups <= '0;
      perf_updates <= '0;
      perf_mispred <= '0;
    end else begin
      prev_pc_q <= if_pc;
      if (!bp_flush) begin
        if (if_pc != prev_pc_q)
          perf_lookups <= perf_lookups + 32'd1;
        if (upd_valid)
          perf_updates <= perf_updates + 32'd1;
        if (upd_valid && mispred)
          perf_mispred <= perf_mispred + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor (ENTRIES=16, TAG_W=8).
module tb_branch_target_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        bp_flush;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_lookups, perf_updates, perf_mispred;
`endif

  int checks   = 0;
  int failures = 0;

  branch_target_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
`ifdef BP_PERF_CNT_EN
    .perf_lookups(perf_lookups),
    .perf_updates(perf_updates),
    .perf_mispred(perf_mispred),
`endif
    .bp_flush    (bp_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one update for a single cycle; the edge happens mid-task
  task automatic drive_update(input logic [31:0] pc, input logic taken,
                              input logic [31:0] target);
    @(negedge clk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = target;
    @(negedge clk);
    upd_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; if_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; bp_flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL reset_hit got=%0b exp=0", pred_hit); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL reset_taken got=%0b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin failures++; $display("[TB] FAIL reset_target got=%h exp=00000104", pred_target); end
    if_pc = 32'hFFFF_FFFC;
    #1;
    checks++; if (pred_target !== 32'h0) begin failures++; $display("[TB] FAIL wrap_target got=%h exp=00000000", pred_target); end
  endtask

  task automatic test_allocate;
    drive_update(32'h100, 1'b1, 32'h40);
    if_pc = 32'h100;
    #1;
    checks++; if (pred_hit !== 1'b1) begin failures++; $display("[TB] FAIL alloc_hit got=%0b exp=1", pred_hit); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("[TB] FAIL alloc_taken got=%0b exp=1", pred_taken); end
    checks++; if (pred_target !== 32'h40) begin failures++; $display("[TB] FAIL alloc_target got=%h exp=00000040", pred_target); end
  endtask

  task automatic test_hysteresis;
    // Same-cycle update must not bypass into the lookup
    @(negedge clk);
    if_pc = 32'h100; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80;
    #1;
    checks++; if (pred_target !== 32'h40) begin failures++; $display("[TB] FAIL no_bypass got=%h exp=00000040", pred_target); end
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    checks++; if (pred_target !== 32'h80) begin failures++; $display("[TB] FAIL target_update got=%h exp=00000080", pred_target); end
    // Two more taken: the third overall would overflow without saturation
    drive_update(32'h100, 1'b1, 32'h80);
    drive_update(32'h100, 1'b1, 32'h80);
    drive_update(32'h100, 1'b0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("[TB] FAIL ctr_st_nt1 got=%0b exp=1", pred_taken); end
    checks++; if (pred_target !== 32'h80) begin failures++; $display("[TB] FAIL ctr_st_nt1_target got=%h exp=00000080", pred_target); end
    drive_update(32'h100, 1'b0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL ctr_wnt_taken got=%0b exp=0", pred_taken); end
    checks++; if (pred_hit !== 1'b1) begin failures++; $display("[TB] FAIL ctr_wnt_hit got=%0b exp=1", pred_hit); end
    checks++; if (pred_target !== 32'h104) begin failures++; $display("[TB] FAIL ctr_wnt_target got=%h exp=00000104", pred_target); end
    repeat (3) drive_update(32'h100, 1'b0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL ctr_underflow got=%0b exp=0", pred_taken); end
    // From SNT one taken reaches WNT only, a second reaches WT
    drive_update(32'h100, 1'b1, 32'h90);
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL ctr_snt_inc got=%0b exp=0", pred_taken); end
    drive_update(32'h100, 1'b1, 32'h90);
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin
      failures++; $display("[TB] FAIL ctr_wt_again got=%0b/%h exp=1/00000090", pred_taken, pred_target);
    end
  endtask

  task automatic test_aliasing;
    drive_update(32'h1100, 1'b1, 32'h300);
    if_pc = 32'h100;
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL alias_old_hit got=%0b exp=0", pred_hit); end
    if_pc = 32'h1100;
    #1;
    checks++; if (pred_hit !== 1'b1 || pred_target !== 32'h300) begin
      failures++; $display("[TB] FAIL alias_new got=%0b/%h exp=1/00000300", pred_hit, pred_target);
    end
    drive_update(32'h104, 1'b0, 32'h500);
    if_pc = 32'h104;
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL nt_no_alloc got=%0b exp=0", pred_hit); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    bp_flush = 1'b1; upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1; upd_target = 32'h700;
    @(negedge clk);
    bp_flush = 1'b0; upd_valid = 1'b0;
    if_pc = 32'h1100;
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL flush_clears got=%0b exp=0", pred_hit); end
    if_pc = 32'h200;
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL flush_drops_upd got=%0b exp=0", pred_hit); end
  endtask

  task automatic test_async_reset;
    drive_update(32'h148, 1'b1, 32'h900);
    if_pc = 32'h148;
    #1;
    checks++; if (pred_hit !== 1'b1 || pred_target !== 32'h900) begin
      failures++; $display("[TB] FAIL pre_rst_hit got=%0b/%h exp=1/00000900", pred_hit, pred_target);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin
      failures++; $display("[TB] FAIL async_rst_out got=%0b/%0b exp=0/0", pred_hit, pred_taken);
    end
    checks++; if (pred_target !== 32'h14C) begin failures++; $display("[TB] FAIL async_rst_target got=%h exp=0000014c", pred_target); end
`ifdef BP_PERF_CNT_EN
    checks++; if (perf_lookups !== 32'd0 || perf_updates !== 32'd0 || perf_mispred !== 32'd0) begin
      failures++; $display("[TB] FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", perf_lookups, perf_updates, perf_mispred);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (pred_hit !== 1'b0) begin failures++; $display("[TB] FAIL post_rst_miss got=%0b exp=0", pred_hit); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_hysteresis();
    test_aliasing();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch target buffer with a 2-bit saturating direction counter per entry, for the 5-stage RISC-V pipeline.
- Replaces static predict-not-taken: IF looks up the current PC combinationally and gets a predicted next PC.
- The EX/MEM resolution stage writes back the actual outcome.
- Mispredict flushing stays in the datapath; this block only predicts and learns.

Parameters:
- XLEN, 32, width of PC and target.
- ENTRIES, 16, number of table entries; power of 2, minimum 2.
- TAG_W, 8, tag bits stored per entry; IDX_W + TAG_W + 2 <= XLEN.
- IDX_W, log2(ENTRIES), derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- if_pc  in  XLEN  PC currently in IF.
- pred_hit  out  1  valid entry with matching tag at if_pc.
- pred_taken  out  1  pred_hit and counter MSB = 1.
- pred_target  out  XLEN  stored target when pred_taken, else if_pc + 4.
- upd_valid  in  1  a resolved conditional branch or jump is in EX/MEM this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  XLEN  actual target address.
- bp_flush  in  1  synchronous invalidate of all entries (fence.i, context switch).

Behaviour:
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid (1), tag (TAG_W), target (XLEN), ctr (2). Encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup is purely combinational from the table flops, with zero-cycle latency.
- Lookup hit: valid[idx] && tag[idx] == tag(if_pc).
- pred_target adder is XLEN bits and wraps modulo 2^XLEN.
- Update is applied on the rising edge when upd_valid = 1.
  - Update hit (same hit rule on upd_pc), upd_taken = 1: ctr increments, saturating at 11; target <= upd_target.
  - Update hit, upd_taken = 0: ctr decrements, saturating at 00; target unchanged; entry stays valid.
  - Update miss, upd_taken = 1: allocate by overwriting any prior occupant. valid <= 1, tag <= tag(upd_pc), target <= upd_target, ctr <= 10.
  - Update miss, upd_taken = 0: no table change. No allocation on not-taken.
- Simultaneous lookup and update to the same index: lookup sees pre-update contents. No write-to-read bypass.
- bp_flush = 1: all valid <= 0 on the next edge; ctr and target are untouched.
- bp_flush together with upd_valid in the same cycle: flush wins and the update is dropped.
- Reset (rst = 0, async, any time including mid-update): all valid = 0, all ctr = 01, all target = 0, all tag = 0.
- Outputs while in reset: pred_hit = 0, pred_taken = 0, pred_target = if_pc + 4.
- No X may propagate from unwritten entries, because all fields are reset.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- When defined, adds three 32-bit outputs:
  - perf_lookups: increments each cycle if_pc changes from the previous cycle.
  - perf_updates: increments on each accepted upd_valid.
  - perf_mispred: increments on an accepted update where the prediction recomputed for upd_pc from pre-update contents differs from the actual outcome. A mismatch is a direction mismatch, or, when both are taken, a target mismatch.
- Counter behaviour: all three reset to 0, wrap at 2^32, and stay frozen while bp_flush = 1.
- When the macro is undefined, the ports and logic do not exist.

Decomposition:
- Shared package bp_pkg holds:
  - ctr encoding constants SNT/WNT/WT/ST.
  - CTR_RESET = WNT and CTR_ALLOC = WT.
  - the entry typedef (valid, tag, target, ctr), parametrised via localparams.
  - index/tag extraction functions.
- One sub-module: bp_sat_counter, a combinational 2-bit saturating next-state with inc/dec inputs. It is instantiated once and shared by the update path.

Test Plan:
- Reset: release rst, if_pc = 0x100 -> pred_hit = 0, pred_taken = 0, pred_target = 0x104.
- Allocate on taken: update upd_pc = 0x100, upd_taken = 1, upd_target = 0x40. Next cycle if_pc = 0x100 -> pred_hit = 1, pred_taken = 1 (ctr 10), pred_target = 0x40.
- Hysteresis and saturation, starting from the entry just allocated at 0x100 (ctr 10):
  - Two taken updates -> ctr 11.
  - One not-taken -> ctr 10, still taken.
  - Second not-taken -> ctr 01, pred_taken = 0, pred_target = 0x104, pred_hit = 1.
  - Three more not-taken -> ctr 00, no underflow.
- Aliasing, ENTRIES = 16: entry at 0x100 valid.
  - Taken update at 0x100 + 0x40·2^6 (same idx, different tag) -> overwrites the entry; lookup 0x100 -> pred_hit = 0.
  - Not-taken miss at an empty index -> no allocation.
- Flush vs update: bp_flush = 1 and upd_valid = 1 (0x200, taken) in the same cycle -> all pred_hit = 0 afterwards; 0x200 not allocated.
- Async reset mid-stream: assert rst low between edges while entries are valid -> outputs drop immediately to their reset values; after release, lookups miss. With BP_PERF_CNT_EN, all counters read 0.
